// File: rtl/axi_lite_master_engine.sv
// Single-outstanding AXI4-Lite master: turns one command into one AW/W/B or AR/R exchange.
// Optional per-phase timeout abort enabled by defining AXIL_MASTER_TIMEOUT_EN.
module axi_lite_master_engine #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                  aclk,
    input  logic                  areset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [STRB_WIDTH-1:0] cmd_wstrb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  rsp_timeout,
    output logic [ADDR_WIDTH-1:0] awaddr,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [STRB_WIDTH-1:0] wstrb,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready
);

    typedef enum logic [2:0] {StIdle, StWaddr, StWresp, StRaddr, StRdata, StResp} state_e;

    state_e state_q;
    logic   aw_done_q, w_done_q;
    logic   aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic   phase_done;
    logic   tmo_hit;

    always_comb begin
        aw_hs = awvalid & awready;
        w_hs  = wvalid & wready;
        b_hs  = bvalid & bready;
        ar_hs = arvalid & arready;
        r_hs  = rvalid & rready;
        phase_done = 1'b0;
        case (state_q)
            StWaddr: phase_done = (aw_done_q | aw_hs) & (w_done_q | w_hs);
            StWresp: phase_done = b_hs;
            StRaddr: phase_done = ar_hs;
            StRdata: phase_done = r_hs;
            default: phase_done = 1'b0;
        endcase
    end

`ifdef AXIL_MASTER_TIMEOUT_EN
    localparam int unsigned CntWidth = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntWidth-1:0] tmo_cnt_q;

    assign tmo_hit = (tmo_cnt_q == CntWidth'(TIMEOUT_CYCLES - 1));

    // Restarts on every state change, so each wait phase gets its own budget.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            tmo_cnt_q <= '0;
        end else if (phase_done || tmo_hit ||
                     !(state_q inside {StWaddr, StWresp, StRaddr, StRdata})) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_q + CntWidth'(1);
        end
    end
`else
    assign tmo_hit     = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state_q   <= StIdle;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= 2'b00;
            awaddr    <= '0;
            awvalid   <= 1'b0;
            wdata     <= '0;
            wstrb     <= '0;
            wvalid    <= 1'b0;
            bready    <= 1'b0;
            araddr    <= '0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
`ifdef AXIL_MASTER_TIMEOUT_EN
            rsp_timeout <= 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        if (cmd_write) begin
                            awaddr    <= cmd_addr;
                            wdata     <= cmd_wdata;
                            wstrb     <= cmd_wstrb;
                            awvalid   <= 1'b1;
                            wvalid    <= 1'b1;
                            aw_done_q <= 1'b0;
                            w_done_q  <= 1'b0;
                            state_q   <= StWaddr;
                        end else begin
                            araddr  <= cmd_addr;
                            arvalid <= 1'b1;
                            state_q <= StRaddr;
                        end
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                StWaddr: begin
                    if (aw_hs) begin
                        awvalid   <= 1'b0;
                        aw_done_q <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid   <= 1'b0;
                        w_done_q <= 1'b1;
                    end
                    if (phase_done) begin
                        bready  <= 1'b1;
                        state_q <= StWresp;
                    end else if (tmo_hit) begin
                        awvalid <= 1'b0;
                        wvalid  <= 1'b0;
                    end
                end
                StWresp: begin
                    if (b_hs) begin
                        bready    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_write <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_resp  <= bresp;
                        state_q   <= StResp;
                    end else if (tmo_hit) begin
                        bready <= 1'b0;
                    end
                end
                StRaddr: begin
                    if (ar_hs) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state_q <= StRdata;
                    end else if (tmo_hit) begin
                        arvalid <= 1'b0;
                    end
                end
                StRdata: begin
                    if (r_hs) begin
                        rready    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_write <= 1'b0;
                        rsp_rdata <= rdata;
                        rsp_resp  <= rresp;
                        state_q   <= StResp;
                    end else if (tmo_hit) begin
                        rready <= 1'b0;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase

            // Abort: channel handshakes were dropped above; synthesize a SLVERR response.
            if (tmo_hit && !phase_done &&
                state_q inside {StWaddr, StWresp, StRaddr, StRdata}) begin
                rsp_valid <= 1'b1;
                rsp_write <= (state_q == StWaddr) || (state_q == StWresp);
                rsp_rdata <= '0;
                rsp_resp  <= 2'b10;
                state_q   <= StResp;
            end
`ifdef AXIL_MASTER_TIMEOUT_EN
            if (state_q == StIdle) begin
                rsp_timeout <= 1'b0;
            end else if (tmo_hit && !phase_done && state_q != StResp) begin
                rsp_timeout <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_axi_lite_master_engine.sv
// Directed bench for axi_lite_master_engine: writes, reads, stalls, error pass-through, reset.
// The timeout scenario runs only when AXIL_MASTER_TIMEOUT_EN is defined.
module tb_axi_lite_master_engine;

`ifdef AXIL_MASTER_TIMEOUT_EN
    localparam int unsigned Tmo = 16;
`else
    localparam int unsigned Tmo = 256;
`endif

    logic        aclk = 1'b0;
    logic        areset_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_write, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    int n_checks = 0;
    int n_errors = 0;

    always #5 aclk = ~aclk;

    axi_lite_master_engine #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .STRB_WIDTH    (4),
        .TIMEOUT_CYCLES(Tmo)
    ) dut (
        .aclk       (aclk),
        .areset_n   (areset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .cmd_wstrb  (cmd_wstrb),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_write  (rsp_write),
        .rsp_rdata  (rsp_rdata),
        .rsp_resp   (rsp_resp),
        .rsp_timeout(rsp_timeout),
        .awaddr     (awaddr),
        .awvalid    (awvalid),
        .awready    (awready),
        .wdata      (wdata),
        .wstrb      (wstrb),
        .wvalid     (wvalid),
        .wready     (wready),
        .bresp      (bresp),
        .bvalid     (bvalid),
        .bready     (bready),
        .araddr     (araddr),
        .arvalid    (arvalid),
        .arready    (arready),
        .rdata      (rdata),
        .rresp      (rresp),
        .rvalid     (rvalid),
        .rready     (rready)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        areset_n = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        rsp_ready = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;

        // Reset state
        #1;
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_awvalid", awvalid, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_awaddr", awaddr, 0);
        check("rst_rsp_resp", rsp_resp, 0);
        check("rst_rsp_timeout", rsp_timeout, 0);
        #3 areset_n = 1'b1;
        step();
        check("rel_cmd_ready", cmd_ready, 1);

        // Write, always-ready slave
        awready = 1'b1; wready = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h10;
        cmd_wdata = 32'hDEAD_BEEF; cmd_wstrb = 4'hF;
        step();
        cmd_valid = 1'b0;
        check("w1_awvalid", awvalid, 1);
        check("w1_wvalid", wvalid, 1);
        check("w1_awaddr", awaddr, 32'h10);
        check("w1_wdata", wdata, 32'hDEAD_BEEF);
        check("w1_wstrb", wstrb, 4'hF);
        check("w1_cmd_ready", cmd_ready, 0);
        check("w1_bready_early", bready, 0);
        bvalid = 1'b1; bresp = 2'b00;
        step();
        check("w1_bready", bready, 1);
        check("w1_aw_drop", awvalid, 0);
        check("w1_w_drop", wvalid, 0);
        check("w1_rsp_not_yet", rsp_valid, 0);
        step();
        bvalid = 1'b0;
        check("w1_rsp_valid", rsp_valid, 1);
        check("w1_rsp_write", rsp_write, 1);
        check("w1_rsp_resp", rsp_resp, 0);
        check("w1_rsp_rdata", rsp_rdata, 0);
        check("w1_bready_off", bready, 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("w1_done_rsp_valid", rsp_valid, 0);
        check("w1_done_cmd_ready", cmd_ready, 1);

        // Write, awready late by 4 cycles, SLVERR response
        awready = 1'b0; wready = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h44;
        cmd_wdata = 32'h0BAD_F00D; cmd_wstrb = 4'h3;
        step();
        cmd_valid = 1'b0;
        check("w2_awvalid_c1", awvalid, 1);
        check("w2_wvalid_c1", wvalid, 1);
        for (int i = 2; i <= 5; i++) begin
            step();
            check("w2_awvalid_hold", awvalid, 1);
            check("w2_wvalid_drop", wvalid, 0);
            check("w2_awaddr_stable", awaddr, 32'h44);
            check("w2_bready_wait", bready, 0);
        end
        awready = 1'b1;
        step();
        check("w2_aw_drop", awvalid, 0);
        check("w2_bready", bready, 1);
        check("w2_awaddr_keep", awaddr, 32'h44);
        bvalid = 1'b1; bresp = 2'b10;
        step();
        bvalid = 1'b0;
        check("w2_rsp_valid", rsp_valid, 1);
        check("w2_rsp_resp", rsp_resp, 2'b10);
        check("w2_rsp_timeout", rsp_timeout, 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("w2_cmd_ready", cmd_ready, 1);

        // Read with two rvalid wait cycles
        arready = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h20;
        step();
        cmd_valid = 1'b0;
        check("r1_arvalid", arvalid, 1);
        check("r1_araddr", araddr, 32'h20);
        check("r1_rready_early", rready, 0);
        step();
        check("r1_rready", rready, 1);
        check("r1_ar_drop", arvalid, 0);
        step();
        check("r1_rready_hold", rready, 1);
        check("r1_no_rsp", rsp_valid, 0);
        rvalid = 1'b1; rdata = 32'h1234_5678; rresp = 2'b00;
        step();
        rvalid = 1'b0; rdata = 32'hFFFF_FFFF;
        check("r1_rsp_valid", rsp_valid, 1);
        check("r1_rsp_rdata", rsp_rdata, 32'h1234_5678);
        check("r1_rsp_write", rsp_write, 0);
        check("r1_rsp_resp", rsp_resp, 0);
        check("r1_rready_off", rready, 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // Read with DECERR, rvalid early (ignored in RADDR), rsp_ready stalled 5 cycles
        rvalid = 1'b1; rdata = 32'hCAFE_0001; rresp = 2'b11;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h30;
        step();
        cmd_valid = 1'b0;
        check("r2_rready_in_raddr", rready, 0);
        step();
        check("r2_rready", rready, 1);
        step();
        rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
        for (int i = 0; i < 5; i++) begin
            check("r2_rsp_valid_hold", rsp_valid, 1);
            check("r2_rdata_hold", rsp_rdata, 32'hCAFE_0001);
            check("r2_resp_hold", rsp_resp, 2'b11);
            check("r2_cmd_ready_low", cmd_ready, 0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("r2_cmd_ready", cmd_ready, 1);

        // Reset in the middle of a write
        awready = 1'b0; wready = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h80; cmd_wdata = 32'h5; cmd_wstrb = 4'h1;
        step();
        cmd_valid = 1'b0;
        check("rs_awvalid_pre", awvalid, 1);
        #2 areset_n = 1'b0;
        #1;
        check("rs_awvalid", awvalid, 0);
        check("rs_wvalid", wvalid, 0);
        check("rs_cmd_ready", cmd_ready, 0);
        check("rs_rsp_valid", rsp_valid, 0);
        check("rs_awaddr", awaddr, 0);
        #1 areset_n = 1'b1;
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
        step();
        check("rs_rel_cmd_ready", cmd_ready, 1);
        for (int i = 0; i < 3; i++) begin
            check("rs_no_rsp", rsp_valid, 0);
            check("rs_no_aw", awvalid, 0);
            step();
        end
        bvalid = 1'b0;

`ifdef AXIL_MASTER_TIMEOUT_EN
        // Write whose B response never arrives
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h90;
        cmd_wdata = 32'h7; cmd_wstrb = 4'hF;
        step();
        cmd_valid = 1'b0;
        step();
        check("to_bready", bready, 1);
        for (int i = 0; i < 15; i++) begin
            step();
            check("to_bready_hold", bready, 1);
            check("to_no_rsp", rsp_valid, 0);
        end
        step();
        check("to_bready_drop", bready, 0);
        check("to_rsp_valid", rsp_valid, 1);
        check("to_rsp_resp", rsp_resp, 2'b10);
        check("to_rsp_timeout", rsp_timeout, 1);
        check("to_rsp_write", rsp_write, 1);
        check("to_rsp_rdata", rsp_rdata, 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("to_cmd_ready", cmd_ready, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
